// File: rtl/dual_port_ram_param.sv
// -----------------------------------------------------------------------------
// dual_port_ram_param
//
// True dual-port RAM with a single clock, a self-clearing power-up sequence
// and same-address conflict detection.
//
// After reset the block runs an INIT sequence that writes zero to every
// address, one per cycle, for DEPTH cycles. While INIT runs, init_busy is high
// and all port requests are ignored. In READY both ports may read or write
// independently:
//   - A read (rd_en=1, wr_en=0) returns registered data one cycle later,
//     together with a one-cycle rd_valid pulse. rd_data holds otherwise.
//   - A write with rd_en also set is a plain write; no read is returned.
//   - Both ports writing the same address: only the PRIORITY_A winner stores.
//   - Any same-address write/write or read/write pair pulses collision one
//     cycle later. Two reads of the same address are not a collision.
//
// Optional feature (compile-time macro RDW_FORWARD_EN):
//   defined   -> a cross-port read of an address written in the same cycle
//                returns the new write data.
//   undefined -> that read returns the previously stored data.
//
// Parameters:
//   DATA_W      word width in bits
//   ADDR_W      address width; DEPTH = 2**ADDR_W
//   PRIORITY_A  write-write winner: 1 = port A, 0 = port B
//
// Ports:
//   clk                   rising-edge clock
//   rst_n                 asynchronous active-low reset
//   wr_enA / wr_enB       per-port write request
//   rd_enA / rd_enB       per-port read request
//   addr_A / addr_B       per-port address
//   wr_dataA / wr_dataB   per-port write data
//   rd_dataA / rd_dataB   registered read data
//   rd_validA / rd_validB one-cycle pulse marking new read data
//   collision             one-cycle pulse after a same-address conflict
//   init_busy             high while the clear sequence runs
// -----------------------------------------------------------------------------
module dual_port_ram_param #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int PRIORITY_A = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_enA,
    input  logic              wr_enB,
    input  logic              rd_enA,
    input  logic              rd_enB,
    input  logic [ADDR_W-1:0] addr_A,
    input  logic [ADDR_W-1:0] addr_B,
    input  logic [DATA_W-1:0] wr_dataA,
    input  logic [DATA_W-1:0] wr_dataB,
    output logic [DATA_W-1:0] rd_dataA,
    output logic [DATA_W-1:0] rd_dataB,
    output logic              rd_validA,
    output logic              rd_validB,
    output logic              collision,
    output logic              init_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam bit A_WINS = (PRIORITY_A != 0);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] init_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    // -------------------------------------------------------------------------
    // FSM state register and clear counter
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples its inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state <= next_state;
            // The counter stops at the last address instead of wrapping.
            if (state == INIT && init_cnt != LAST_ADDR) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the block can leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        init_busy  = 1'b0;
        unique case (state)
            INIT: begin
                init_busy = 1'b1;
                if (init_cnt == LAST_ADDR) begin
                    next_state = READY;
                end
            end
            READY: begin
                next_state = READY;
            end
            default: begin
                next_state = INIT;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Request qualification
    // -------------------------------------------------------------------------
    logic ready;
    logic same_addr;
    logic we_a;
    logic we_b;
    logic rd_a;
    logic rd_b;
    logic coll_now;

    assign ready     = (state == READY);
    assign same_addr = (addr_A == addr_B);

    // On a same-address double write, the losing port's enable is dropped.
    assign we_a = ready && wr_enA && !(wr_enB && same_addr && !A_WINS);
    assign we_b = ready && wr_enB && !(wr_enA && same_addr &&  A_WINS);

    // A write on the same port takes precedence over its read.
    assign rd_a = ready && rd_enA && !wr_enA;
    assign rd_b = ready && rd_enB && !wr_enB;

    assign coll_now = ready && same_addr &&
                      ((wr_enA && wr_enB) || (rd_a && wr_enB) || (rd_b && wr_enA));

    // -------------------------------------------------------------------------
    // Read data selection (read-during-write behaviour)
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] next_rd_a;
    logic [DATA_W-1:0] next_rd_b;

`ifdef RDW_FORWARD_EN
    // A reading port is never writing, so a cross-port write to the same
    // address is necessarily the winning write and can be forwarded directly.
    assign next_rd_a = (we_b && addr_B == addr_A) ? wr_dataB : mem[addr_A];
    assign next_rd_b = (we_a && addr_A == addr_B) ? wr_dataA : mem[addr_B];
`else
    assign next_rd_a = mem[addr_A];
    assign next_rd_b = mem[addr_B];
`endif

    // -------------------------------------------------------------------------
    // Storage array
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset branch; it is cleared by the INIT sequence,
    // which lets it map onto RAM primitives that cannot be reset.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[init_cnt] <= '0;
        end else begin
            if (we_a) begin
                mem[addr_A] <= wr_dataA;
            end
            if (we_b) begin
                mem[addr_B] <= wr_dataB;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dataA  <= '0;
            rd_dataB  <= '0;
            rd_validA <= 1'b0;
            rd_validB <= 1'b0;
            collision <= 1'b0;
        end else begin
            rd_validA <= rd_a;
            rd_validB <= rd_b;
            collision <= coll_now;
            if (rd_a) begin
                rd_dataA <= next_rd_a;
            end
            if (rd_b) begin
                rd_dataB <= next_rd_b;
            end
        end
    end

endmodule

// File: tb/tb_dual_port_ram_param.sv
// -----------------------------------------------------------------------------
// tb_dual_port_ram_param
//
// Scoreboard bench for dual_port_ram_param (DATA_W=8, ADDR_W=4). The driver
// pushes the expected read data and the expected output cycle for each read,
// and the expected cycle of each collision pulse. A monitor on the falling
// edge pops and compares whenever rd_valid or collision is seen, and checks
// that rd_data holds between valid pulses.
// -----------------------------------------------------------------------------
module tb_dual_port_ram_param;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 4;
    localparam int PRIORITY_A = 1;

    // Word left at address 0x8 after the double write of 0xCC (A) / 0xDD (B).
    localparam logic [7:0] WW_WORD = (PRIORITY_A != 0) ? 8'hCC : 8'hDD;
`ifdef RDW_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              wr_enA = 1'b0;
    logic              wr_enB = 1'b0;
    logic              rd_enA = 1'b0;
    logic              rd_enB = 1'b0;
    logic [ADDR_W-1:0] addr_A = '0;
    logic [ADDR_W-1:0] addr_B = '0;
    logic [DATA_W-1:0] wr_dataA = '0;
    logic [DATA_W-1:0] wr_dataB = '0;
    logic [DATA_W-1:0] rd_dataA;
    logic [DATA_W-1:0] rd_dataB;
    logic              rd_validA;
    logic              rd_validB;
    logic              collision;
    logic              init_busy;

    dual_port_ram_param #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .PRIORITY_A(PRIORITY_A)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_enA   (wr_enA),
        .wr_enB   (wr_enB),
        .rd_enA   (rd_enA),
        .rd_enB   (rd_enB),
        .addr_A   (addr_A),
        .addr_B   (addr_B),
        .wr_dataA (wr_dataA),
        .wr_dataB (wr_dataB),
        .rd_dataA (rd_dataA),
        .rd_dataB (rd_dataB),
        .rd_validA(rd_validA),
        .rd_validB(rd_validB),
        .collision(collision),
        .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   qc[$];
    logic [7:0] last_a = '0;
    logic [7:0] last_b = '0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_validA) begin
                if (qa.size() == 0) begin
                    check("rd_a_unexpected_valid", rd_validA, 0);
                end else begin
                    exp_t e;
                    e = qa.pop_front();
                    check("rd_a_data", rd_dataA, e.data);
                    check("rd_a_cycle", cyc, e.cyc);
                    last_a = e.data;
                end
            end else begin
                check("rd_a_hold", rd_dataA, last_a);
            end
            if (rd_validB) begin
                if (qb.size() == 0) begin
                    check("rd_b_unexpected_valid", rd_validB, 0);
                end else begin
                    exp_t e;
                    e = qb.pop_front();
                    check("rd_b_data", rd_dataB, e.data);
                    check("rd_b_cycle", cyc, e.cyc);
                    last_b = e.data;
                end
            end else begin
                check("rd_b_hold", rd_dataB, last_b);
            end
            if (collision) begin
                if (qc.size() == 0) begin
                    check("coll_unexpected", collision, 0);
                end else begin
                    check("coll_cycle", cyc, qc.pop_front());
                end
            end
        end
    end

    // ----------------------------------------------------------------- driver
    task automatic op(input logic wa, input logic ra, input logic [3:0] aa, input logic [7:0] da,
                      input logic wb, input logic rb, input logic [3:0] ab, input logic [7:0] db,
                      input logic [7:0] ea, input logic [7:0] eb, input logic ec);
        @(posedge clk);
        #1;
        wr_enA = wa; rd_enA = ra; addr_A = aa; wr_dataA = da;
        wr_enB = wb; rd_enB = rb; addr_B = ab; wr_dataB = db;
        if (ra && !wa) qa.push_back(exp_t'{ea, cyc + 1});
        if (rb && !wb) qb.push_back(exp_t'{eb, cyc + 1});
        if (ec) qc.push_back(cyc + 1);
    endtask

    task automatic idle();
        op(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 8'h00, 8'h00, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_dataA"}, rd_dataA, 0);
        check({tag, "_rd_dataB"}, rd_dataB, 0);
        check({tag, "_rd_validA"}, rd_validA, 0);
        check({tag, "_rd_validB"}, rd_validB, 0);
        check({tag, "_collision"}, collision, 0);
        check({tag, "_init_busy"}, init_busy, 1);
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        qc.delete();
        last_a = '0;
        last_b = '0;
    endtask

    // Counts falling edges with init_busy high, stopping at stop_at or when
    // init_busy drops. Bounded so a stuck FSM still reaches the summary.
    // When inject is set, requests are driven during INIT that must be ignored.
    task automatic count_init(output int n, input int stop_at, input bit inject);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!init_busy) break;
            n++;
            if (inject && n == 5) begin
                wr_enA = 1'b1; addr_A = 4'h0; wr_dataA = 8'h55;
                rd_enB = 1'b1; addr_B = 4'h1;
            end
            if (inject && n == 7) begin
                wr_enA = 1'b0; rd_enB = 1'b0;
            end
            if (n == stop_at) break;
        end
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        int n;

        #2;
        assert_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");

        // Release; requests during INIT must be ignored.
        rst_n = 1'b1;
        count_init(n, 100, 1'b1);
        check("init_cycles", n, 16);
        check("init_busy_low", init_busy, 0);

        // Clear: addr 0xF and addr 0x0 (written during INIT) read as zero.
        op(0, 1, 4'hF, 8'h00, 0, 1, 4'h0, 8'h00, 8'h00, 8'h00, 0);
        // Dual write to different addresses, then read both back.
        op(1, 0, 4'h3, 8'hAA, 1, 0, 4'h5, 8'hBB, 8'h00, 8'h00, 0);
        op(0, 1, 4'h3, 8'h00, 0, 1, 4'h5, 8'h00, 8'hAA, 8'hBB, 0);
        // Write-write conflict on 0x8, then read it.
        op(1, 0, 4'h8, 8'hCC, 1, 0, 4'h8, 8'hDD, 8'h00, 8'h00, 1);
        op(0, 1, 4'h8, 8'h00, 0, 0, 4'h0, 8'h00, WW_WORD, 8'h00, 0);
        // A reads 0x8 while B writes 0xEE there; then read 0x8 again.
        op(0, 1, 4'h8, 8'h00, 1, 0, 4'h8, 8'hEE, FWD ? 8'hEE : WW_WORD, 8'h00, 1);
        op(0, 1, 4'h8, 8'h00, 0, 0, 4'h0, 8'h00, 8'hEE, 8'h00, 0);
        // B reads 0x5 while A writes 0x11 there.
        op(1, 0, 4'h5, 8'h11, 0, 1, 4'h5, 8'h00, 8'h00, FWD ? 8'h11 : 8'hBB, 1);
        // Same-port write+read: write wins, no read returned.
        op(1, 1, 4'h4, 8'h44, 0, 0, 4'h0, 8'h00, 8'h00, 8'h00, 0);
        op(0, 1, 4'h4, 8'h00, 0, 1, 4'h5, 8'h00, 8'h44, 8'h11, 0);
        // Two reads of the same address: no collision, same data.
        op(0, 1, 4'h3, 8'h00, 0, 1, 4'h3, 8'h00, 8'hAA, 8'hAA, 0);
        // Idle cycles: read data must hold.
        repeat (4) idle();
        @(negedge clk);
        check("pre_reset_rd_dataA", rd_dataA, 8'hAA);

        // Reset mid-READY: outputs clear asynchronously.
        @(posedge clk);
        #1;
        assert_reset();
        #1;
        check_reset_outputs("rst_ready");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset again at INIT cycle 7.
        count_init(n, 7, 1'b0);
        check("partial_init_cycles", n, 7);
        assert_reset();
        #1;
        check_reset_outputs("rst_init");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_init(n, 100, 1'b0);
        check("reinit_cycles", n, 16);

        // Data written before reset is gone.
        op(0, 1, 4'h3, 8'h00, 0, 1, 4'h8, 8'h00, 8'h00, 8'h00, 0);
        repeat (3) idle();
        @(negedge clk);

        check("qa_leftover", qa.size(), 0);
        check("qb_leftover", qb.size(), 0);
        check("qc_leftover", qc.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dual_port_ram_param.md
DUAL_PORT_RAM_PARAM -- requirements
Module: dual_port_ram_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, which is the word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, which is the address width; DEPTH = 2**ADDR_W.
REQ-003 The block SHALL have parameter PRIORITY_A, default 1, which selects the write-write winner (1 = port A, 0 = port B).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have ports wr_enA and wr_enB, input, 1 bit each: per-port write request.
REQ-007 The block SHALL have ports rd_enA and rd_enB, input, 1 bit each: per-port read request.
REQ-008 The block SHALL have ports addr_A and addr_B, input, ADDR_W bits each: per-port address.
REQ-009 The block SHALL have ports wr_dataA and wr_dataB, input, DATA_W bits each: per-port write data.
REQ-010 The block SHALL have ports rd_dataA and rd_dataB, output, DATA_W bits each: registered read data.
REQ-011 The block SHALL have ports rd_validA and rd_validB, output, 1 bit each: one-cycle pulse marking a new rd_data.
REQ-012 The block SHALL have port collision, output, 1 bit: one-cycle pulse on a same-address conflict.
REQ-013 The block SHALL have port init_busy, output, 1 bit: high while the memory-clear sequence runs.

Function
REQ-014 The block SHALL implement a two-state FSM, INIT and READY, and SHALL enter INIT on reset.
REQ-015 In INIT, an internal ADDR_W-bit counter SHALL write zero to address 0..DEPTH-1, one address per cycle, and the FSM SHALL move to READY after DEPTH cycles.
REQ-016 init_busy SHALL be 1 in INIT and 0 in READY.
REQ-017 In INIT, all port requests SHALL be ignored: no writes, rd_valid stays 0, collision stays 0.
REQ-018 In READY, a write (wr_enX=1) SHALL update mem[addr_X] at the sampling clk edge.
REQ-019 In READY, a read (rd_enX=1, wr_enX=0) SHALL drive rd_dataX on the next cycle (latency 1) with rd_validX=1 for exactly that one cycle.
REQ-020 rd_dataX SHALL hold its last value whenever rd_validX=0.
REQ-021 When wr_enX and rd_enX are both 1 on the same port, the write SHALL take effect and no read SHALL occur (rd_validX=0).
REQ-022 When both ports write to different addresses, both writes SHALL complete in the same cycle.
REQ-023 When both ports write to the same address, only the PRIORITY_A winner's data SHALL be stored, the loser's write SHALL be discarded, and collision SHALL pulse 1 on the next cycle.
REQ-024 When one port reads and the other port writes to the same address, collision SHALL pulse 1 on the next cycle, and the returned data SHALL follow REQ-030.
REQ-025 Two reads of the same address SHALL not be a collision, and both ports SHALL return the same data.
REQ-026 Addresses SHALL be used modulo DEPTH with no out-of-range case, and the INIT counter SHALL terminate at DEPTH-1 without wrap-around.

Reset
REQ-027 While rst_n=0, rd_dataA/B SHALL be 0, rd_validA/B SHALL be 0, collision SHALL be 0, init_busy SHALL be 1, and the FSM SHALL be in INIT with the counter at 0, all asynchronously.
REQ-028 Reset asserted mid-INIT or mid-READY SHALL abort any in-flight read, and the full DEPTH-cycle clear SHALL restart after rst_n rises.
REQ-029 Memory contents SHALL not be reset directly; they SHALL be zeroed only by the INIT sequence.

Configuration
REQ-030 The read-during-write result SHALL be controlled by macro RDW_FORWARD_EN: if defined, a cross-port read of the address being written SHALL return the new write data (the winner's data if both ports write); if undefined, it SHALL return the old stored data.

Verification
REQ-031 Clear sequence (DATA_W=8, ADDR_W=4): release rst_n -> init_busy=1 for 16 cycles then 0; a subsequent read of addr 0xF -> rd_data=0x00 with rd_valid=1 one cycle later.
REQ-032 Dual write: A writes 0xAA to 0x3 and B writes 0xBB to 0x5 in the same cycle; next cycle A reads 0x3 and B reads 0x5 -> rd_dataA=0xAA, rd_dataB=0xBB, both rd_valid pulse once, collision=0.
REQ-033 Write-write conflict: A writes 0xCC and B writes 0xDD, both to 0x8 -> collision pulses once; a read of 0x8 -> 0xCC with PRIORITY_A=1, 0xDD with PRIORITY_A=0.
REQ-034 Read-during-write (mem[8]=0xCC): A reads 0x8 while B writes 0xEE to 0x8 -> rd_dataA=0xCC without RDW_FORWARD_EN, 0xEE with it; collision pulses; the next read of 0x8 -> 0xEE.
REQ-035 Reset mid-INIT, then after READY: write 0xAA to 0x3, then pull rst_n low at INIT cycle 7 -> all outputs 0, init_busy=1, a fresh 16-cycle INIT runs, and a read of 0x3 -> 0x00.
